conv2d_3x3_engine: RTL and testbench
====================================

Name: conv2d_3x3_engine

Overview:
- 2D convolution processor for a fixed 8x8 signed 8-bit image and a 3x3 signed kernel, valid-mode only.
- Produces 36 signed 16-bit results (6x6) in row-major order.
- Contains the 64x8 image memory (single-port, synchronous read) that is loaded through a write port.
- Results are streamed out as a contiguous 36-cycle burst.

Parameters:
- KERNEL, default 72'h01_01_01_01_01_01_01_01_01, nine signed 8-bit coefficients, k0 in bits [7:0], row-major k0..k8.
- ACC_W, default 20, internal accumulator width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- in_st  in  1  load phase; high while the image is being written; its falling edge starts computation.
- wr  in  1  write enable (active-high), honoured only while in_st=1 and the engine is not computing.
- address  in  6  image memory address, row-major (row*8+col).
- din  in  8  signed pixel write data.
- dout  out  16  signed convolution result.
- out_st  out  1  high on every cycle dout carries a valid result.
- busy  out  1  high from compute start until the last result has been output.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; dout=0, out_st=0, busy=0; result counters cleared. Memory contents are not cleared.
- States:
  - IDLE: waiting; in_st=1 moves to LOAD.
  - LOAD: each cycle with wr=1 writes din to mem[address]; last write to an address wins. The first cycle in_st samples 0 moves to CALC; busy rises on that edge.
  - CALC: computes all results into an internal 36x16 result buffer.
  - OUT: streams the buffer.
  - OUT returns to IDLE after result 35; busy falls with out_st.
- Result definition: R(r,c) = sum over i,j in 0..2 of mem[(r+i)*8+(c+j)] * k[i*3+j], for r,c in 0..5.
  - Result index n = r*6+c.
  - Signed 8x8 products, accumulated in ACC_W-bit signed.
  - Saturated to 16-bit signed: >32767 gives 32767, <-32768 gives -32768.
- CALC timing: each result takes exactly 10 cycles (9 memory reads, one cycle per tap; 1-cycle read latency; final accumulate and buffer write). CALC lasts exactly 360 cycles.
- OUT timing: out_st=1 for exactly 36 consecutive cycles. dout = result 0..35 in order, one per cycle. out_st first asserts on the clock edge after the final CALC cycle.
- When out_st=0, dout holds its last value (0 after reset).
- Ignored inputs:
  - wr while busy=1 (memory is protected during CALC/OUT).
  - in_st while busy=1.
  - wr while in_st=0.
- A new run may begin the cycle after busy falls. Memory keeps its contents, so re-pulsing in_st with no writes recomputes the same image.
- Reset mid-CALC or mid-OUT aborts immediately: out_st=0, busy=0 on the next edge; no partial burst continues.
- Address and counter wrap: the result counter stops at 35 and never wraps into a 37th output.

Test Plan:
- Default all-ones kernel; load mem[i]=1 for all 64 → out_st high for exactly 36 consecutive cycles, every dout=9; busy falls with the last one.
- Default kernel; mem[i]=i for i=0..63 → dout sequence R(r,c)=9*(8r+c+9): first 81, then 90; index 6 (r=1,c=0) = 153; last = 486.
- KERNEL all 8'sd127, mem all 127 → every dout=32767 (saturate). mem all -128 → every dout=-32768.
- Latency check: after in_st falls, out_st first high exactly 361 edges later; wr pulses during CALC do not change results.
- Reset: assert rst_n=0 during the OUT burst at result 10 → out_st=0, busy=0, dout=0 next cycle; a re-run without reloading reproduces the full original 36 results.
- Kernel 0,0,0,0,1,0,0,0,0 with random pixels → dout(n) = mem[(r+1)*8+(c+1)], verifying ordering and addressing.

Source files
------------

// File: rtl/conv2d_3x3_engine.sv
// 3x3 valid-mode convolution over a fixed 8x8 signed image held in on-chip memory.
// One tap per cycle feeds a single MAC; the 36 results are buffered, then burst out.
module conv2d_3x3_engine #(
  parameter logic [71:0] KERNEL = 72'h01_01_01_01_01_01_01_01_01,
  parameter int          ACC_W  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_st,
  input  logic        wr,
  input  logic [5:0]  address,
  input  logic [7:0]  din,
  output logic [15:0] dout,
  output logic        out_st,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  state_t                  state_q, state_d;
  logic [3:0]              tap_q, tap_d;
  logic [2:0]              row_q, row_d;
  logic [2:0]              col_q, col_d;
  logic [5:0]              res_q, res_d;
  logic [5:0]              out_cnt_q, out_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              pix_q;
  logic [15:0]             dout_q;

  logic [7:0]              img_mem [64];
  logic [15:0]             res_buf [36];
  logic signed [7:0]       kern [9];

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_kern
      assign kern[gi] = KERNEL[gi*8 +: 8];
    end
  endgenerate

  logic [4:0]              tap_off;
  logic [5:0]              rd_addr;
  logic [5:0]              mem_addr;
  logic [3:0]              coef_idx;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic [15:0]             sat_val;
  logic                    mem_we;
  logic                    buf_we;

  // Window offset of each tap relative to the top-left pixel of the window.
  always_comb begin
    tap_off = 5'd0;
    case (tap_q)
      4'd1:    tap_off = 5'd1;
      4'd2:    tap_off = 5'd2;
      4'd3:    tap_off = 5'd8;
      4'd4:    tap_off = 5'd9;
      4'd5:    tap_off = 5'd10;
      4'd6:    tap_off = 5'd16;
      4'd7:    tap_off = 5'd17;
      4'd8:    tap_off = 5'd18;
      default: tap_off = 5'd0;
    endcase
  end

  // The pixel arriving this cycle was addressed by the previous tap.
  always_comb begin
    rd_addr  = {row_q, 3'b000} + {3'b000, col_q} + {1'b0, tap_off};
    mem_addr = (state_q == S_CALC) ? rd_addr : address;
    coef_idx = (tap_q == 4'd0) ? 4'd0 : tap_q - 4'd1;
    prod     = $signed(pix_q) * kern[coef_idx];
    prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    acc_sum  = (tap_q == 4'd1) ? prod_ext : acc_q + prod_ext;
    if (acc_sum > SAT_MAX) begin
      sat_val = 16'h7FFF;
    end else if (acc_sum < SAT_MIN) begin
      sat_val = 16'h8000;
    end else begin
      sat_val = acc_sum[15:0];
    end
    mem_we = wr && in_st && ((state_q == S_IDLE) || (state_q == S_LOAD));
    buf_we = (state_q == S_CALC) && (tap_q == 4'd9);
  end

  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    row_d     = row_q;
    col_d     = col_q;
    res_d     = res_q;
    out_cnt_d = out_cnt_q;
    acc_d     = acc_q;
    case (state_q)
      S_IDLE: begin
        if (in_st) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!in_st) begin
          state_d = S_CALC;
          tap_d   = 4'd0;
          row_d   = 3'd0;
          col_d   = 3'd0;
          res_d   = 6'd0;
        end
      end
      S_CALC: begin
        if (tap_q != 4'd0) acc_d = acc_sum;
        if (tap_q == 4'd9) begin
          tap_d = 4'd0;
          res_d = res_q + 6'd1;
          if (col_q == 3'd5) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
          if (res_q == 6'd35) begin
            state_d   = S_OUT;
            out_cnt_d = 6'd0;
          end
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      S_OUT: begin
        if (out_cnt_q == 6'd35) state_d = S_IDLE;
        else                    out_cnt_d = out_cnt_q + 6'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tap_q     <= 4'd0;
      row_q     <= 3'd0;
      col_q     <= 3'd0;
      res_q     <= 6'd0;
      out_cnt_q <= 6'd0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      row_q     <= row_d;
      col_q     <= col_d;
      res_q     <= res_d;
      out_cnt_q <= out_cnt_d;
      acc_q     <= acc_d;
    end
  end

  // Single-port image memory: written while loading, read by the MAC during compute.
  always_ff @(posedge clk) begin
    if (mem_we) img_mem[mem_addr] <= din;
    pix_q <= img_mem[mem_addr];
  end

  always_ff @(posedge clk) begin
    if (buf_we) res_buf[res_q] <= sat_val;
  end

  // Result 0 is fetched on the edge that enters the burst, so dout is valid with out_st.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= 16'd0;
    end else if (state_d == S_OUT) begin
      dout_q <= res_buf[out_cnt_d];
    end
  end

  assign dout   = dout_q;
  assign out_st = (state_q == S_OUT);
  assign busy   = (state_q == S_CALC) || (state_q == S_OUT);

endmodule

// File: tb/tb_conv2d_3x3_engine.sv
// Bench for conv2d_3x3_engine: four kernels side by side on a shared load bus,
// checked against a direct sum-of-products model of the 6x6 valid convolution.
module tb_conv2d_3x3_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_st;
  logic        wr;
  logic [5:0]  address;
  logic [7:0]  din;
  logic [15:0] dout_w [4];
  logic        out_st_w [4];
  logic        busy_w [4];

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int img[64];
  int res_got[4][36];
  int ktab[4][9] = '{
    '{1, 1, 1, 1, 1, 1, 1, 1, 1},
    '{127, 127, 127, 127, 127, 127, 127, 127, 127},
    '{0, 0, 0, 0, 1, 0, 0, 0, 0},
    '{-3, 5, -128, 7, -1, 2, 127, -64, 9}
  };

  conv2d_3x3_engine u_def (
    .clk(clk), .rst_n(rst_n), .in_st(in_st), .wr(wr), .address(address), .din(din),
    .dout(dout_w[0]), .out_st(out_st_w[0]), .busy(busy_w[0])
  );

  conv2d_3x3_engine #(.KERNEL(72'h7F_7F_7F_7F_7F_7F_7F_7F_7F)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_st(in_st), .wr(wr), .address(address), .din(din),
    .dout(dout_w[1]), .out_st(out_st_w[1]), .busy(busy_w[1])
  );

  conv2d_3x3_engine #(.KERNEL(72'h00_00_00_00_01_00_00_00_00)) u_ctr (
    .clk(clk), .rst_n(rst_n), .in_st(in_st), .wr(wr), .address(address), .din(din),
    .dout(dout_w[2]), .out_st(out_st_w[2]), .busy(busy_w[2])
  );

  conv2d_3x3_engine #(.KERNEL(72'h09_C0_7F_02_FF_07_80_05_FD)) u_mix (
    .clk(clk), .rst_n(rst_n), .in_st(in_st), .wr(wr), .address(address), .din(din),
    .dout(dout_w[3]), .out_st(out_st_w[3]), .busy(busy_w[3])
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_res(int k, int n);
    int r = n / 6;
    int c = n % 6;
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += img[(r + i) * 8 + c + j] * ktab[k][i * 3 + j];
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s;
  endfunction

  // One full run: optional load, compute, burst capture (or reset abort), compare.
  task automatic run(input int id, input bit do_load, input bit noise, input int abort_at);
    int n;
    int last_i;
    in_st = 1'b1;
    wr    = 1'b0;
    tick();
    if (do_load) begin
      for (int g = 0; g < 4; g++) begin
        wr = 1'b1; address = 6'($urandom_range(0, 63)); din = 8'($urandom); tick();
      end
      for (int a = 0; a < 64; a++) begin
        wr = 1'b1; address = 6'(a); din = 8'(img[a]); tick();
      end
    end
    wr    = 1'b0;
    in_st = 1'b0;
    check($sformatf("run%0d busy_pre", id), int'(busy_w[0]), 0);
    n = 0;
    while (n < 1000 && !out_st_w[0]) begin
      tick();
      n++;
      if (n == 1) check($sformatf("run%0d busy_start", id), int'(busy_w[0]), 1);
      if (noise && n < 300) begin
        wr = 1'($urandom); in_st = 1'($urandom);
        address = 6'($urandom); din = 8'($urandom);
      end else begin
        wr = 1'b0; in_st = 1'b0;
      end
    end
    check($sformatf("run%0d latency", id), n, 361);
    if (out_st_w[0]) begin
      last_i = 35;
      for (int i = 0; i < 36; i++) begin
        for (int k = 0; k < 4; k++) begin
          res_got[k][i] = int'($signed(dout_w[k]));
          check($sformatf("run%0d k%0d n%0d out_st", id, k, i), int'(out_st_w[k]), 1);
          check($sformatf("run%0d k%0d n%0d busy", id, k, i), int'(busy_w[k]), 1);
        end
        if (i == abort_at) begin
          last_i = i;
          rst_n = 1'b0;
          tick();
          for (int k = 0; k < 4; k++) begin
            check($sformatf("run%0d k%0d abort out_st", id, k), int'(out_st_w[k]), 0);
            check($sformatf("run%0d k%0d abort busy", id, k), int'(busy_w[k]), 0);
            check($sformatf("run%0d k%0d abort dout", id, k), int'(dout_w[k]), 0);
          end
          rst_n = 1'b1;
          tick();
          for (int k = 0; k < 4; k++)
            check($sformatf("run%0d k%0d abort quiet", id, k), int'(out_st_w[k]), 0);
          break;
        end
        tick();
      end
      if (abort_at < 0) begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("run%0d k%0d end out_st", id, k), int'(out_st_w[k]), 0);
          check($sformatf("run%0d k%0d end busy", id, k), int'(busy_w[k]), 0);
          check($sformatf("run%0d k%0d hold dout", id, k), int'($signed(dout_w[k])), model_res(k, 35));
        end
      end
      for (int k = 0; k < 4; k++)
        for (int i = 0; i <= last_i; i++)
          check($sformatf("run%0d k%0d res%0d", id, k, i), res_got[k][i], model_res(k, i));
      $display("run %0d: latency=%0d results=%0d def0=%0d mix0=%0d", id, n, last_i + 1,
               res_got[0][0], res_got[3][0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_st = 1'b0; wr = 1'b0; address = 6'd0; din = 8'd0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset k%0d dout", k), int'(dout_w[k]), 0);
      check($sformatf("reset k%0d out_st", k), int'(out_st_w[k]), 0);
      check($sformatf("reset k%0d busy", k), int'(busy_w[k]), 0);
    end
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 64; a++) img[a] = 1;
    run(1, 1'b1, 1'b0, -1);
    check("ones n0", res_got[0][0], 9);
    check("ones n35", res_got[0][35], 9);

    for (int a = 0; a < 64; a++) img[a] = a;
    run(2, 1'b1, 1'b0, -1);
    check("ramp n0", res_got[0][0], 81);
    check("ramp n1", res_got[0][1], 90);
    check("ramp n6", res_got[0][6], 153);
    check("ramp n35", res_got[0][35], 486);

    for (int a = 0; a < 64; a++) img[a] = 127;
    run(3, 1'b1, 1'b0, -1);
    check("satpos n0", res_got[1][0], 32767);
    check("satpos n35", res_got[1][35], 32767);

    for (int a = 0; a < 64; a++) img[a] = -128;
    run(4, 1'b1, 1'b0, -1);
    check("satneg n0", res_got[1][0], -32768);
    check("satneg n35", res_got[1][35], -32768);

    for (int r = 5; r <= 7; r++) begin
      for (int a = 0; a < 64; a++) img[a] = int'($urandom_range(0, 255)) - 128;
      run(r, 1'b1, 1'b1, -1);
      check($sformatf("rand%0d ctr n7", r), res_got[2][7], img[2 * 8 + 2]);
    end

    run(8, 1'b0, 1'b0, 10);

    // Writes with in_st low must not disturb the stored image.
    for (int g = 0; g < 3; g++) begin
      wr = 1'b1; in_st = 1'b0; address = 6'($urandom); din = 8'($urandom); tick();
    end
    wr = 1'b0;
    run(9, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
